mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the single-cycle CPU's instruction and data ports. It answers instruction fetches and data loads/stores from one single-ported word array. A 1-deep request slot per port and an alternating-priority arbiter ensure the array performs at most one access per cycle. It sits between the CPU top level and the testbench/SoC, replacing separate behavioural instruction and data memories.

## Interface
Parameters:
- DEPTH_WORDS, 16384, number of 32-bit words in the backing array (power of two).
- ADDR_W, $clog2(DEPTH_WORDS), word-index width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- instr_read  in  1  instruction fetch request.
- instr_addr  in  32  byte address of fetch.
- instr_ready  out  1  instruction slot empty; fetch accepted this cycle when instr_read && instr_ready.
- instr_out  out  32  fetched word; holds until the next fetch completes.
- instr_valid  out  1  one-cycle pulse when instr_out is updated.
- data_read  in  1  load request.
- data_write  in  4  store byte enables; bit k writes byte k.
- data_addr  in  32  byte address of load/store.
- data_in  in  32  store data, lane-aligned.
- data_ready  out  1  data slot empty; request accepted when (data_read || |data_write) && data_ready.
- data_out  out  32  loaded word; holds until the next load completes.
- data_valid  out  1  one-cycle pulse on load completion. Stores also pulse it; data_out is then unchanged.

## Operation
- Word index is addr[ADDR_W+1:2]. addr[1:0] is ignored for indexing. Higher bits are ignored unless MEM_ERR_EN is defined.
- Each port has a 1-deep slot (valid, addr, byte enables, data). An accepted request fills the slot. The slot empties on the cycle the array services it.
- Bypass: a request accepted into an empty slot may be serviced in the same cycle if it wins arbitration.
- Arbiter: one array access per cycle. If only one slot holds a request, it wins. If both do, the winner is selected by prio:
  - prio=0: data wins, then prio becomes 1.
  - prio=1: instruction wins, then prio becomes 0.
  - prio toggles only when there was a conflict.
- Store: the selected bytes are merged into the addressed word. Bytes with a 0 enable are preserved.
- Load+store in the same request (data_read && |data_write): read-before-write. data_out returns the pre-store word, and the store is applied.
- Request with data_write==0 and data_read==0: not a request; ignored.

## Timing
- Read latency: an accepted and immediately serviced request returns instr_out/data_out with a valid pulse at the next posedge, i.e. visible one cycle after acceptance.
- Conflict loser: serviced the following cycle, for a two-cycle latency. Its ready stays low for exactly that one cycle.
- Back-to-back same-address store then load: the load sees the new data. The array is written at the service edge.
- Requester must hold its request and fields while ready is low. Fields are sampled only at acceptance.
- Reset (async, any time, including mid-conflict):
  - slots cleared; prio=0.
  - instr_ready=1, data_ready=1.
  - instr_out=0, data_out=0, instr_valid=0, data_valid=0.
  - Array contents are not cleared.
  - A request in flight at reset is discarded and produces no valid pulse.

## Configuration
- MEM_ERR_EN defined:
  - Adds output port mem_err (1 bit, reset 0). It pulses for one cycle with the valid pulse of any serviced access whose addr[31:ADDR_W+2] is nonzero.
  - An out-of-range store is suppressed (no array write).
  - An out-of-range load returns 32'hDEAD_BEEF.
  - Adds a 16-bit saturating err_count output, reset 0.
- MEM_ERR_EN undefined: no mem_err or err_count ports. Upper address bits are ignored, so accesses alias.

## Structure
- A shared package holds:
  - the request-slot struct (valid, is_instr, rd, be[3:0], idx, wdata);
  - the constants ERR_WORD=32'hDEAD_BEEF and ERR_CNT_W=16.
- One sub-module, mem_byte_array, holds the storage: single port, byte-enable write, read-before-write, synchronous read. The slots, arbiter, output registers and error logic live in mem_responder.

## Test plan
- Reset then store data_write=4'b1111, addr=0x10, data=0x11223344; then load addr=0x10 -> data_out=0x11223344 with data_valid one cycle after acceptance.
- Byte store data_write=4'b0100, data=0x00AB0000 to a word holding 0x11223344 -> later load returns 0x11AB3344.
- Same-cycle fetch addr 0x0 and load addr 0x10 with prio=0 -> data serviced first. instr_ready is low one cycle and instr_out updates one cycle after data_out. On the next conflict the instruction wins.
- Load+store same request at a word holding 0x5 with data 0x9 -> data_out=0x5; a subsequent load returns 0x9.
- Assert rst while the instruction slot is pending -> outputs zero immediately, both ready high, no instr_valid pulse after release.
- MEM_ERR_EN: load addr=DEPTH_WORDS*4 -> data_out=0xDEADBEEF, mem_err pulse, err_count=1. A store to the same address leaves word 0 unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared types and constants for the memory responder: the
//            request-slot record and the error word/counter width.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    // Word address carried in a slot: addr[31:2]. The full width is kept so
    // out-of-range detection can look at the bits above the array index.
    localparam int IDX_W = 30;

    localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;
    localparam int          ERR_CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic             is_instr;
        logic             rd;
        logic [3:0]       be;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
    } req_slot_t;

    // Build a slot record from raw port fields.
    function automatic req_slot_t make_req(input logic        valid,
                                           input logic        is_instr,
                                           input logic        rd,
                                           input logic [3:0]  be,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata);
        req_slot_t r;
        r.valid    = valid;
        r.is_instr = is_instr;
        r.rd       = rd;
        r.be       = be;
        r.idx      = addr[31:2];
        r.wdata    = wdata;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
// Module   : mem_byte_array
// Purpose  : Single-port 32-bit word storage with per-byte write enables,
//            synchronous read and read-before-write behaviour.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_byte_array #(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    // One byte-wide array per lane so each byte enable maps to its own write port.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Read the old byte and optionally overwrite it on the same edge.
        always_ff @(posedge clk) begin
            if (en_i) begin
                rd_q <= mem_q[addr_i];
                if (we_i[k]) begin
                    mem_q[addr_i] <= wdata_i[8*k +: 8];
                end
            end
        end

        assign rdata_o[8*k +: 8] = rd_q;
    end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Instruction/data memory responder. One request slot per port,
//            an alternating-priority arbiter and a single-ported word array.
// Config   : define MEM_ERR_EN to add out-of-range detection (mem_err,
//            err_count, suppressed stores, ERR_WORD on reads).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic        instr_ready,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic        data_ready,
    output logic [31:0] data_out,
    output logic        data_valid
`ifdef MEM_ERR_EN
    ,
    output logic                 mem_err,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    req_slot_t   islot_q, islot_d, dslot_q, dslot_d;
    req_slot_t   inew, dnew, icand, dcand, win;
    logic        prio_q, prio_d;
    logic        grant_i, grant_d, conflict, win_err;
    logic        ivalid_q, dvalid_q, drd_q, err_q;
    logic [31:0] ihold_q, dhold_q;
    logic [31:0] rdata, read_word;
    logic [3:0]  arr_we;

    assign instr_ready = !islot_q.valid;
    assign data_ready  = !dslot_q.valid;

    // Candidate selection, arbitration and next slot/priority state.
    always_comb begin
        inew = make_req(instr_read && instr_ready, 1'b1, 1'b1, 4'b0000,
                        instr_addr, 32'h0);
        dnew = make_req((data_read || (|data_write)) && data_ready, 1'b0,
                        data_read, data_write, data_addr, data_in);

        // A held slot takes precedence; otherwise a fresh request bypasses.
        icand = islot_q.valid ? islot_q : inew;
        dcand = dslot_q.valid ? dslot_q : dnew;

        conflict = icand.valid && dcand.valid;
        grant_i  = icand.valid && (!dcand.valid || prio_q);
        grant_d  = dcand.valid && (!icand.valid || !prio_q);
        win      = grant_i ? icand : dcand;

        islot_d = (icand.valid && !grant_i) ? icand : '0;
        dslot_d = (dcand.valid && !grant_d) ? dcand : '0;
        prio_d  = conflict ? !prio_q : prio_q;
    end

`ifdef MEM_ERR_EN
    assign win_err = win.valid && ((win.idx >> ADDR_W) != '0);
`else
    assign win_err = 1'b0;
`endif

    // Out-of-range stores never reach the array.
    assign arr_we = win.be & {4{!win_err}};

    mem_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (win.valid),
        .we_i    (arr_we),
        .addr_i  (win.idx[ADDR_W-1:0]),
        .wdata_i (win.wdata),
        .rdata_o (rdata)
    );

    // Reads of either port that were flagged out of range return ERR_WORD.
    assign read_word = err_q ? ERR_WORD : rdata;

    // Slot, priority and service-record registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            islot_q  <= '0;
            dslot_q  <= '0;
            prio_q   <= 1'b0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            drd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            islot_q  <= islot_d;
            dslot_q  <= dslot_d;
            prio_q   <= prio_d;
            ivalid_q <= grant_i;
            dvalid_q <= grant_d;
            drd_q    <= grant_d && dcand.rd;
            err_q    <= win_err;
        end
    end

    // Capture the returned word so the outputs hold between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ihold_q <= '0;
            dhold_q <= '0;
        end else begin
            if (ivalid_q) begin
                ihold_q <= read_word;
            end
            if (dvalid_q && drd_q) begin
                dhold_q <= read_word;
            end
        end
    end

    assign instr_valid = ivalid_q;
    assign data_valid  = dvalid_q;
    assign instr_out   = ivalid_q ? read_word : ihold_q;
    assign data_out    = (dvalid_q && drd_q) ? read_word : dhold_q;

`ifdef MEM_ERR_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of serviced out-of-range accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (win_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign mem_err   = err_q;
    assign err_count = err_cnt_q;
`endif

    // Byte-offset bits, the is_instr tag and (when unchecked) high index bits
    // carry no function here.
    logic unused_bits;
    assign unused_bits = ^{instr_addr[1:0], data_addr[1:0], win};

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        data_ready;
    logic [31:0] data_out;
    logic        data_valid;
`ifdef MEM_ERR_EN
    logic                 mem_err;
    logic [ERR_CNT_W-1:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_read  (instr_read),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .data_read   (data_read),
        .data_write  (data_write),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .data_ready  (data_ready),
        .data_out    (data_out),
        .data_valid  (data_valid)
`ifdef MEM_ERR_EN
        ,
        .mem_err     (mem_err),
        .err_count   (err_count)
`endif
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_read = 1'b0;
        instr_addr = '0;
        data_read  = 1'b0;
        data_write = 4'b0000;
        data_addr  = '0;
        data_in    = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        data_read = 1'b0; data_write = be; data_addr = a; data_in = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %b want 1", instr_ready); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready got %b want 1", data_ready); end
        checks++; if ({instr_valid, data_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {instr_valid, data_valid}); end
        checks++; if (instr_out !== 32'h0 || data_out !== 32'h0) begin errors++; $display("FAIL reset_outs got %h/%h want 0/0", instr_out, data_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        data_write = 4'b1111; data_addr = 32'h10; data_in = 32'h1122_3344;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b want 1", data_ready); end
        step();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL store_valid got %b want 1", data_valid); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL store_dout_unchanged got %h want 0", data_out); end
        data_write = 4'b0000; data_read = 1'b1;
        step();
        idle();
        checks++; if (data_valid !== 1'b1 || data_out !== 32'h1122_3344) begin errors++; $display("FAIL load_word got v=%b %h want v=1 11223344", data_valid, data_out); end
        step();
        checks++; if (data_valid !== 1'b0 || data_out !== 32'h1122_3344) begin errors++; $display("FAIL load_hold got v=%b %h want v=0 11223344", data_valid, data_out); end
    endtask

    task automatic test_byte_store();
        store(32'h10, 4'b0100, 32'h00AB_0000);
        data_read = 1'b1; data_addr = 32'h10;
        step();
        idle();
        checks++; if (data_out !== 32'h11AB_3344) begin errors++; $display("FAIL byte_merge got %h want 11ab3344", data_out); end
    endtask

    task automatic test_conflict();
        store(32'h0, 4'b1111, 32'hCAFE_0001);
        step();
        // First conflict: data wins.
        instr_read = 1'b1; instr_addr = 32'h0;
        data_read  = 1'b1; data_addr  = 32'h10;
        step();
        data_read = 1'b0;
        checks++; if (data_valid !== 1'b1 || data_out !== 32'h11AB_3344) begin errors++; $display("FAIL conf1_data got v=%b %h want v=1 11ab3344", data_valid, data_out); end
        checks++; if (instr_valid !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL conf1_instr_wait got v=%b rdy=%b want 0 0", instr_valid, instr_ready); end
        step();
        idle();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'hCAFE_0001 || instr_ready !== 1'b1) begin errors++; $display("FAIL conf1_instr got v=%b %h rdy=%b want 1 cafe0001 1", instr_valid, instr_out, instr_ready); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL conf1_data_pulse got %b want 0", data_valid); end
        // Second conflict: instruction wins.
        instr_read = 1'b1; instr_addr = 32'h0;
        data_read  = 1'b1; data_addr  = 32'h10;
        step();
        instr_read = 1'b0;
        checks++; if (instr_valid !== 1'b1 || data_valid !== 1'b0 || data_ready !== 1'b0) begin errors++; $display("FAIL conf2_instr got iv=%b dv=%b drdy=%b want 1 0 0", instr_valid, data_valid, data_ready); end
        step();
        idle();
        checks++; if (data_valid !== 1'b1 || data_ready !== 1'b1 || data_out !== 32'h11AB_3344) begin errors++; $display("FAIL conf2_data got v=%b rdy=%b %h want 1 1 11ab3344", data_valid, data_ready, data_out); end
        step();
    endtask

    task automatic test_rmw();
        store(32'h20, 4'b1111, 32'h5);
        data_read = 1'b1; data_write = 4'b1111; data_addr = 32'h20; data_in = 32'h9;
        step();
        idle();
        checks++; if (data_valid !== 1'b1 || data_out !== 32'h5) begin errors++; $display("FAIL rmw_old got v=%b %h want 1 5", data_valid, data_out); end
        data_read = 1'b1; data_addr = 32'h20;
        step();
        idle();
        checks++; if (data_out !== 32'h9) begin errors++; $display("FAIL rmw_new got %h want 9", data_out); end
    endtask

    task automatic test_back_to_back();
        instr_read = 1'b1; instr_addr = 32'h0;
        step();
        instr_addr = 32'h10;
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_fetch0 got v=%b %h want 1 cafe0001", instr_valid, instr_out); end
        step();
        idle();
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h11AB_3344) begin errors++; $display("FAIL b2b_fetch1 got v=%b %h want 1 11ab3344", instr_valid, instr_out); end
        // Store immediately followed by a load of the same word.
        data_write = 4'b0011; data_addr = 32'h30; data_in = 32'hFFFF_BEEF;
        step();
        data_write = 4'b0000; data_read = 1'b1;
        step();
        idle();
        checks++; if (data_out[15:0] !== 16'hBEEF) begin errors++; $display("FAIL b2b_store_load got %h want ....beef", data_out); end
        step();
    endtask

    task automatic test_reset_mid();
        int ipulses;
        instr_read = 1'b1; instr_addr = 32'h0;
        data_read  = 1'b1; data_addr  = 32'h10;
        step();
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got rdy=%b want 0", instr_ready); end
        rst = 1'b1;
        #1;
        idle();
        checks++; if (instr_ready !== 1'b1 || data_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b%b want 11", instr_ready, data_ready); end
        checks++; if (instr_out !== 32'h0 || data_out !== 32'h0 || instr_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL mid_outs got %h %h %b%b want 0 0 00", instr_out, data_out, instr_valid, data_valid); end
        step();
        rst = 1'b0;
        ipulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (instr_valid === 1'b1) ipulses++;
        end
        checks++; if (ipulses != 0) begin errors++; $display("FAIL mid_no_pulse got %0d pulses want 0", ipulses); end
        // Priority was cleared: data must win the next conflict.
        instr_read = 1'b1; instr_addr = 32'h0;
        data_read  = 1'b1; data_addr  = 32'h10;
        step();
        data_read = 1'b0;
        checks++; if (data_valid !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_prio got dv=%b iv=%b want 1 0", data_valid, instr_valid); end
        step();
        idle();
        step();
    endtask

`ifdef MEM_ERR_EN
    task automatic test_mem_err();
        data_read = 1'b1; data_addr = DEPTH * 4;
        step();
        idle();
        checks++; if (data_out !== 32'hDEAD_BEEF || mem_err !== 1'b1 || err_count !== 16'd1) begin errors++; $display("FAIL err_load got %h err=%b cnt=%0d want deadbeef 1 1", data_out, mem_err, err_count); end
        step();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", mem_err); end
        store(DEPTH * 4, 4'b1111, 32'h1234_5678);
        data_read = 1'b1; data_addr = 32'h0;
        step();
        idle();
        checks++; if (data_out !== 32'hCAFE_0001 || err_count !== 16'd2) begin errors++; $display("FAIL err_store got %h cnt=%0d want cafe0001 2", data_out, err_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_conflict();
        test_rmw();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_ERR_EN
        test_mem_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
